wb_sdram_arb: RTL and testbench

// Two-master pipelined Wishbone arbiter in front of the single SDRAM Wishbone slave port (the DDR3 bridge on
// o_sys_clk). Master A is the CPU, master B is DMA/video. Grant is held per bus cycle with round-robin tie-break.
// A burst-length limit preempts an owner that starves the other master. Acks/errs route back to the granted master.
//

---
 rtl/wb_sdram_arb_pkg.sv | 6 +
 rtl/wb_arb_outstanding.sv | 23 ++
 rtl/wb_sdram_arb.sv | 119 +++++++++++
 tb/tb_wb_sdram_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wb_sdram_arb_pkg.sv
// wb_sdram_arb_pkg: shared state encoding and default sizing for the SDRAM Wishbone arbiter.
package wb_sdram_arb_pkg;
  localparam int DEF_LGOUT    = 5;
  localparam int DEF_MAXBURST = 64;
  typedef enum logic [2:0] {IDLE, OWN_A, OWN_B, DRAIN_A, DRAIN_B} arb_state_t;
endpackage

// File: rtl/wb_arb_outstanding.sv
// wb_arb_outstanding: up/down count of un-acked requests with full/empty flags.
module wb_arb_outstanding
  import wb_sdram_arb_pkg::*;
#(
  parameter int LGOUT = DEF_LGOUT
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);
  logic [LGOUT-1:0] r_cnt;
  assign o_full  = &r_cnt;
  assign o_empty = r_cnt == '0;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !i_dec && !o_full) r_cnt <= r_cnt + 1'b1;
    else if (i_dec && !i_inc && !o_empty) r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/wb_sdram_arb.sv
// wb_sdram_arb: two-master pipelined Wishbone arbiter with round-robin tie-break and
// burst-limit preemption in front of the single SDRAM slave port.
module wb_sdram_arb
  import wb_sdram_arb_pkg::*;
#(
  parameter int AW       = 26,
  parameter int DW       = 32,
  parameter int LGOUT    = DEF_LGOUT,
  parameter int MAXBURST = DEF_MAXBURST,
  parameter int SELW     = DW / 8
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [SELW-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  output logic [DW-1:0]   o_a_data,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [SELW-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_b_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [SELW-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);
  localparam int BW = $clog2(MAXBURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAXBURST);

  arb_state_t    r_state;
  logic          r_last;
  logic [BW-1:0] r_burst;
  logic w_own_a, w_own_b, w_drain, w_cyc, w_stb, w_other, w_preempt, w_block;
  logic w_acc, w_ack, w_end, w_full, w_empty, w_stall;

  assign w_own_a   = r_state == OWN_A || r_state == DRAIN_A;
  assign w_own_b   = r_state == OWN_B || r_state == DRAIN_B;
  assign w_drain   = r_state == DRAIN_A || r_state == DRAIN_B;
  assign w_cyc     = w_own_a ? i_a_cyc : w_own_b ? i_b_cyc : 1'b0;
  assign w_stb     = w_own_a ? i_a_stb : w_own_b ? i_b_stb : 1'b0;
  assign w_other   = w_own_a ? i_b_cyc : i_a_cyc;
  assign w_preempt = !w_drain && r_burst == MAXB && w_other;
  // Any reason the owner's strobe must not reach the slave this cycle
  assign w_block   = w_drain || w_preempt || w_full || i_wb_err;
  assign w_acc     = o_wb_stb && !i_wb_stall;
  assign w_ack     = i_wb_ack && !w_empty && (w_own_a || w_own_b);
  assign w_end     = (w_own_a || w_own_b) && (!w_cyc || i_wb_err);
  assign w_stall   = i_wb_stall || w_block;

  assign o_wb_cyc  = w_cyc;
  assign o_wb_stb  = w_cyc && w_stb && !w_block;
  assign o_wb_we   = w_own_a ? i_a_we   : w_own_b ? i_b_we   : 1'b0;
  assign o_wb_addr = w_own_a ? i_a_addr : w_own_b ? i_b_addr : '0;
  assign o_wb_data = w_own_a ? i_a_data : w_own_b ? i_b_data : '0;
  assign o_wb_sel  = w_own_a ? i_a_sel  : w_own_b ? i_b_sel  : '0;

  assign o_a_stall = !w_own_a || w_stall;
  assign o_b_stall = !w_own_b || w_stall;
  assign o_a_ack   = w_own_a && w_ack;
  assign o_b_ack   = w_own_b && w_ack;
  assign o_a_err   = w_own_a && i_wb_err;
  assign o_b_err   = w_own_b && i_wb_err;
  assign o_a_data  = i_wb_data;
  assign o_b_data  = i_wb_data;

  wb_arb_outstanding #(.LGOUT(LGOUT)) u_outstanding (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clr    (w_end),
    .i_inc    (w_acc),
    .i_dec    (w_ack),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // r_last: 0 = A had the bus last, 1 = B
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_burst <= '0;
    end else if (w_end) begin
      r_state <= IDLE;
      r_last  <= w_own_b;
      r_burst <= '0;
    end else begin
      case (r_state)
        IDLE: r_state <= (i_a_cyc && (!i_b_cyc || r_last)) ? OWN_A : i_b_cyc ? OWN_B : IDLE;
        OWN_A, OWN_B: begin
          if (w_acc && r_burst != MAXB) r_burst <= r_burst + 1'b1;
          if (w_preempt) r_state <= w_own_a ? DRAIN_A : DRAIN_B;
        end
        DRAIN_A, DRAIN_B: if (w_empty) begin
          r_state <= w_own_a ? OWN_B : OWN_A;
          r_last  <= w_own_b;
          r_burst <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_sdram_arb.sv
// tb_wb_sdram_arb: directed self-checking bench for wb_sdram_arb.
module tb_wb_sdram_arb;
  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_a_cyc, i_a_stb, i_a_we, i_b_cyc, i_b_stb, i_b_we;
  logic [25:0] i_a_addr, i_b_addr, o_wb_addr;
  logic [31:0] i_a_data, i_b_data, o_a_data, o_b_data, o_wb_data, i_wb_data;
  logic [3:0]  i_a_sel, i_b_sel, o_wb_sel;
  logic        o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
  logic        o_wb_cyc, o_wb_stb, o_wb_we, i_wb_stall, i_wb_ack, i_wb_err;
  logic        ack_man, auto_ack, r_sack;
  int          n_tot, n_pass, n_acc, n_low, n_ack_a, s_acc, s_low, s_ack;

  always #5 i_clk = ~i_clk;
  assign i_wb_ack = ack_man | r_sack;

  wb_sdram_arb dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
    .i_a_data(i_a_data), .i_a_sel(i_a_sel), .o_a_stall(o_a_stall), .o_a_ack(o_a_ack),
    .o_a_err(o_a_err), .o_a_data(o_a_data),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
    .i_b_data(i_b_data), .i_b_sel(i_b_sel), .o_b_stall(o_b_stall), .o_b_ack(o_b_ack),
    .o_b_err(o_b_err), .o_b_data(o_b_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_stall(i_wb_stall),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  // Slave model (one-cycle auto ack) and event counters
  initial begin
    r_sack = 1'b0; n_acc = 0; n_low = 0; n_ack_a = 0;
  end
  always @(posedge i_clk) begin
    r_sack <= auto_ack & o_wb_stb & ~i_wb_stall;
    if (o_wb_stb && !i_wb_stall) n_acc <= n_acc + 1;
    if (!o_wb_cyc) n_low <= n_low + 1;
    if (o_a_ack) n_ack_a <= n_ack_a + 1;
  end

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b required %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  initial begin
    n_tot = 0; n_pass = 0;
    i_reset_n = 1'b0;
    {i_a_cyc, i_a_stb, i_a_we, i_b_cyc, i_b_stb, i_b_we} = '0;
    i_a_addr = 26'h100; i_b_addr = 26'h200; i_a_data = 32'h11111111; i_b_data = 32'h22222222;
    i_a_sel = 4'hF; i_b_sel = 4'hF;
    i_wb_stall = 1'b0; i_wb_err = 1'b0; i_wb_data = '0; ack_man = 1'b0; auto_ack = 1'b0;
    #1;
    chk1("rst_a_stall", o_a_stall, 1'b1);
    chk1("rst_b_stall", o_b_stall, 1'b1);
    chk1("rst_cyc", o_wb_cyc, 1'b0);
    chk1("rst_stb", o_wb_stb, 1'b0);
    chk1("rst_a_ack", o_a_ack, 1'b0);
    repeat (2) step;
    i_reset_n = 1'b1;
    step;

    // 1: single read from A
    i_a_cyc = 1'b1; i_a_stb = 1'b1; #1;
    chk1("t1_stb_wait", o_wb_stb, 1'b0);
    step;
    chk1("t1_stb", o_wb_stb, 1'b1);
    chk32("t1_addr", 32'(o_wb_addr), 32'h100);
    chk1("t1_a_stall", o_a_stall, 1'b0);
    step;
    i_a_stb = 1'b0; ack_man = 1'b1; i_wb_data = 32'hDEADBEEF; #1;
    chk1("t1_a_ack", o_a_ack, 1'b1);
    chk32("t1_a_data", o_a_data, 32'hDEADBEEF);
    chk1("t1_b_ack", o_b_ack, 1'b0);
    step;
    ack_man = 1'b0; i_a_cyc = 1'b0; #1;
    chk1("t1_cyc_drop", o_wb_cyc, 1'b0);
    step;

    // 2: tie after reset goes to A, then round-robin to B
    i_reset_n = 1'b0; #1; i_reset_n = 1'b1;
    i_a_cyc = 1'b1; i_b_cyc = 1'b1;
    step;
    chk1("t2_a_grant", o_a_stall, 1'b0);
    chk1("t2_b_wait", o_b_stall, 1'b1);
    i_a_cyc = 1'b0; #1;
    chk1("t2_a_drop", o_wb_cyc, 1'b0);
    step;
    i_a_cyc = 1'b1;
    step;
    chk1("t2_b_grant", o_b_stall, 1'b0);
    chk1("t2_a_wait", o_a_stall, 1'b1);
    i_a_cyc = 1'b0; i_b_cyc = 1'b0;
    step;

    // 3: outstanding limit of 31
    i_a_cyc = 1'b1; i_a_stb = 1'b1;
    step;
    s_acc = n_acc;
    repeat (30) step;
    chk1("t3_30_open", o_a_stall, 1'b0);
    step;
    chk1("t3_31_stall", o_a_stall, 1'b1);
    chk1("t3_31_nostb", o_wb_stb, 1'b0);
    chk32("t3_acc31", 32'(n_acc - s_acc), 32'd31);
    ack_man = 1'b1; #1;
    chk1("t3_ack", o_a_ack, 1'b1);
    step;
    ack_man = 1'b0; #1;
    chk1("t3_slot_free", o_a_stall, 1'b0);
    step;
    chk1("t3_full_again", o_a_stall, 1'b1);
    chk32("t3_acc32", 32'(n_acc - s_acc), 32'd32);
    i_a_cyc = 1'b0; i_a_stb = 1'b0;
    step;

    // 4: burst-limit preemption with B waiting
    auto_ack = 1'b1; i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_we = 1'b1;
    step;
    i_b_cyc = 1'b1; i_b_stb = 1'b1;
    s_acc = n_acc; s_low = n_low; s_ack = n_ack_a;
    for (int i = 0; i < 200 && o_b_stall; i++) step;
    chk1("t4_b_grant", o_b_stall, 1'b0);
    chk1("t4_a_held", o_a_stall, 1'b1);
    chk32("t4_a_accepts", 32'(n_acc - s_acc), 32'd64);
    chk32("t4_a_acks", 32'(n_ack_a - s_ack), 32'd64);
    chk32("t4_cyc_low", 32'(n_low - s_low), 32'd0);
    chk32("t4_b_addr", 32'(o_wb_addr), 32'h200);
    i_b_stb = 1'b0; i_a_stb = 1'b0; i_a_we = 1'b0;
    repeat (2) step;
    auto_ack = 1'b0; i_a_cyc = 1'b0; i_b_cyc = 1'b0;
    step;

    // 5: error on B's third of five reads, A pending
    i_b_cyc = 1'b1; i_b_stb = 1'b1;
    step;
    i_a_cyc = 1'b1;
    repeat (5) step;
    i_b_stb = 1'b0; ack_man = 1'b1;
    repeat (2) step;
    ack_man = 1'b0; i_wb_err = 1'b1; #1;
    chk1("t5_b_err", o_b_err, 1'b1);
    chk1("t5_a_err", o_a_err, 1'b0);
    chk1("t5_b_ack", o_b_ack, 1'b0);
    step;
    i_wb_err = 1'b0; i_b_cyc = 1'b0; ack_man = 1'b1; #1;
    chk1("t5_cyc_low", o_wb_cyc, 1'b0);
    chk1("t5_err_once", o_b_err, 1'b0);
    chk1("t5_stray_b", o_b_ack, 1'b0);
    step;
    chk1("t5_a_grant", o_a_stall, 1'b0);
    chk1("t5_cyc_back", o_wb_cyc, 1'b1);
    chk1("t5_stray_a", o_a_ack, 1'b0);
    ack_man = 1'b0;

    // 6: asynchronous reset mid-burst
    auto_ack = 1'b1; i_a_stb = 1'b1;
    repeat (3) step;
    chk1("t6_busy", o_wb_stb, 1'b1);
    #2 i_reset_n = 1'b0; #1;
    chk1("t6_cyc", o_wb_cyc, 1'b0);
    chk1("t6_stb", o_wb_stb, 1'b0);
    chk32("t6_addr", 32'(o_wb_addr), 32'h0);
    chk1("t6_a_stall", o_a_stall, 1'b1);
    chk1("t6_b_stall", o_b_stall, 1'b1);
    chk1("t6_a_ack", o_a_ack, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
